// File: rtl/vga_pkg.sv
// Shared types and screen geometry for the VGA plot arbiter.
package vga_pkg;
  localparam int VGA_W = 160;
  localparam int VGA_H = 120;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int CW    = 3;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IW-1:0]      pick_idx
);
  function automatic int slot_idx(input logic [IW-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  function automatic logic [NUM_REQ-1:0] slot_mask(input logic [IW-1:0] ptr, input int off);
    return NUM_REQ'(1) << slot_idx(ptr, off);
  endfunction

  // Walk from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if ((req & slot_mask(rr_ptr, i)) != '0) begin
        pick_oh  = slot_mask(rr_ptr, i);
        pick_idx = IW'(slot_idx(rr_ptr, i));
      end
    end
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter plot port between NUM_REQ engines: round-robin grant,
// per-grant plot budget, registered and clipped pixel forwarding.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ-1:0][XW-1:0]  req_x,
  input  logic [NUM_REQ-1:0][YW-1:0]  req_y,
  input  logic [NUM_REQ-1:0][CW-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]          req_plot,
  output logic [XW-1:0]               vga_x,
  output logic [YW-1:0]               vga_y,
  output logic [CW-1:0]               vga_colour,
  output logic                        vga_plot,
  output logic                        busy,
  output logic [15:0]                 clip_cnt,
  output arb_state_t                  state_dbg
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int BW = 16;

  // Handshake: an engine holds req for its whole burst and may only treat a
  // req_plot as taken on a cycle where it sees its own gnt bit high; strobes
  // without gnt are silently dropped and never counted.

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      burst_q, burst_d;
  pixel_t             pix_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               accept, in_range, others_pending, burst_last;
  logic [IW-1:0]      owner_next;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  always_comb begin
    accept         = (state_q == GRANT) && req_plot[owner_q] && gnt_q[owner_q];
    in_range       = (req_x[owner_q] < XW'(VGA_W)) && (req_y[owner_q] < YW'(VGA_H));
    others_pending = |(req & ~gnt_q);
    burst_last     = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST - 1));
    owner_next     = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      // HANDOFF already holds the advanced rr_ptr, so it shares IDLE's pick.
      IDLE, HANDOFF: begin
        gnt_d = '0;
        if (|req) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          burst_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (accept) burst_d = burst_last ? '0 : burst_q + BW'(1);
        if (!req[owner_q] || (accept && burst_last && others_pending)) begin
          state_d  = HANDOFF;
          gnt_d    = '0;
          rr_ptr_d = owner_next;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      pix_q    <= '0;
      vga_plot <= 1'b0;
      clip_cnt <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      vga_plot <= accept && in_range;
      if (accept && in_range) begin
        pix_q.x      <= req_x[owner_q];
        pix_q.y      <= req_y[owner_q];
        pix_q.colour <= req_colour[owner_q];
      end
      if (accept && !in_range && (clip_cnt != 16'hFFFF)) clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign gnt        = gnt_q;
  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.colour;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter (NUM_REQ=2, MAX_BURST=4).
module tb_vga_plot_arbiter;
  import vga_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0][7:0]  req_x;
  logic [1:0][6:0]  req_y;
  logic [1:0][2:0]  req_colour;
  logic [1:0]       req_plot;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot;
  logic             busy;
  logic [15:0]      clip_cnt;
  arb_state_t       state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_pix;

  vga_plot_arbiter #(.NUM_REQ(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .clip_cnt(clip_cnt), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; req_plot = '0;
    req_x = '0; req_y = '0; req_colour = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_cmp++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b want 0", vga_plot); end
    n_cmp++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin n_fail++; $display("FAIL reset_pix: got %0d,%0d,%0d want 0,0,0", vga_x, vga_y, vga_colour); end
    n_cmp++; if (busy !== 1'b0 || clip_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_busy_clip: got busy=%b clip=%0d want 0,0", busy, clip_cnt); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_single();
    req = 2'b01;
    tick();
    n_cmp++; if (gnt !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got gnt=%b busy=%b want 01,1", gnt, busy); end
    for (int k = 0; k < 3; k++) begin
      req_plot = 2'b01;
      req_x[0] = 8'(10 + k); req_y[0] = 7'd20; req_colour[0] = 3'(3 + k);
      exp_q.push_back({8'(10 + k), 7'd20, 3'(3 + k)});
      tick();
      n_cmp++;
      if (vga_plot !== 1'b1 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL single_plot%0d: got plot=%b want 1", k, vga_plot);
      end else begin
        exp_pix = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== exp_pix) begin
          n_fail++; $display("FAIL single_pix%0d: got %h want %h", k, {vga_x, vga_y, vga_colour}, exp_pix);
        end
      end
    end
    req_plot = 2'b00;
    tick();
    n_cmp++; if (vga_plot !== 1'b0 || vga_x !== 8'd12) begin n_fail++; $display("FAIL single_hold: got plot=%b x=%0d want 0,12", vga_plot, vga_x); end
    req = 2'b00;
    tick();
    n_cmp++; if (state_dbg !== HANDOFF || gnt !== 2'b00) begin n_fail++; $display("FAIL single_release: got state=%0d gnt=%b want HANDOFF,00", state_dbg, gnt); end
    tick();
    n_cmp++; if (state_dbg !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got state=%0d busy=%b want IDLE,0", state_dbg, busy); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    req = 2'b11;
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", gnt); end
    req = 2'b10;
    tick();
    n_cmp++; if (gnt !== 2'b00 || state_dbg !== HANDOFF) begin n_fail++; $display("FAIL rr_handoff: got gnt=%b state=%0d want 00,HANDOFF", gnt, state_dbg); end
    tick();
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rr_second: got %b want 10", gnt); end
    req = 2'b00;
    tick(); tick();
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rr_idle: got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_burst();
    // rr_ptr wrapped back to 0 after engine 1 released.
    req = 2'b11;
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL burst_gnt0: got %b want 01", gnt); end
    req_plot = 2'b01; req_y[0] = 7'd2; req_colour[0] = 3'd1;
    for (int k = 0; k < 4; k++) begin
      req_x[0] = 8'(k + 1);
      tick();
      n_cmp++; if (vga_plot !== 1'b1 || vga_x !== 8'(k + 1)) begin n_fail++; $display("FAIL burst0_fwd%0d: got plot=%b x=%0d want 1,%0d", k, vga_plot, vga_x, k + 1); end
    end
    n_cmp++; if (gnt !== 2'b00 || state_dbg !== HANDOFF) begin n_fail++; $display("FAIL burst0_force: got gnt=%b state=%0d want 00,HANDOFF", gnt, state_dbg); end
    tick();
    n_cmp++; if (gnt !== 2'b10 || vga_plot !== 1'b0) begin n_fail++; $display("FAIL burst_gnt1: got gnt=%b plot=%b want 10,0", gnt, vga_plot); end
    req_plot = 2'b11; req_y[1] = 7'd9; req_colour[1] = 3'd6;
    for (int k = 0; k < 4; k++) begin
      req_x[1] = 8'(50 + k);
      tick();
      n_cmp++; if (vga_plot !== 1'b1 || vga_x !== 8'(50 + k) || vga_y !== 7'd9) begin n_fail++; $display("FAIL burst1_fwd%0d: got plot=%b x=%0d y=%0d want 1,%0d,9", k, vga_plot, vga_x, vga_y, 50 + k); end
    end
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL burst1_force: got %b want 00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b01 || vga_plot !== 1'b0) begin n_fail++; $display("FAIL burst_back0: got gnt=%b plot=%b want 01,0", gnt, vga_plot); end
    req_plot = 2'b00; req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_clip();
    reset_dut();
    req = 2'b01;
    tick();
    req_plot = 2'b01;
    req_x[0] = 8'd160; req_y[0] = 7'd5; req_colour[0] = 3'd2;
    tick();
    n_cmp++; if (vga_plot !== 1'b0 || clip_cnt !== 16'd1) begin n_fail++; $display("FAIL clip_x: got plot=%b clip=%0d want 0,1", vga_plot, clip_cnt); end
    req_x[0] = 8'd3; req_y[0] = 7'd120;
    tick();
    n_cmp++; if (vga_plot !== 1'b0 || clip_cnt !== 16'd2) begin n_fail++; $display("FAIL clip_y: got plot=%b clip=%0d want 0,2", vga_plot, clip_cnt); end
    req_x[0] = 8'd159; req_y[0] = 7'd119; req_colour[0] = 3'd7;
    tick();
    n_cmp++; if (vga_plot !== 1'b1 || {vga_x, vga_y, vga_colour} !== {8'd159, 7'd119, 3'd7} || clip_cnt !== 16'd2) begin
      n_fail++; $display("FAIL clip_edge: got plot=%b pix=%0d,%0d,%0d clip=%0d want 1,159,119,7,2", vga_plot, vga_x, vga_y, vga_colour, clip_cnt);
    end
    req_plot = 2'b00;
  endtask

  task automatic test_ungranted_plot();
    // Engine 0 still owns the port; engine 1 strobes without gnt.
    req_plot = 2'b10;
    req_x[1] = 8'd30; req_y[1] = 7'd30;
    tick();
    n_cmp++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL nognt_plot: got %b want 0", vga_plot); end
    req_x[1] = 8'd200;
    req = 2'b11;
    tick();
    n_cmp++; if (vga_plot !== 1'b0 || clip_cnt !== 16'd2) begin n_fail++; $display("FAIL nognt_clip: got plot=%b clip=%0d want 0,2", vga_plot, clip_cnt); end
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL nognt_keep: got %b want 01", gnt); end
  endtask

  task automatic test_reset_mid_burst();
    req = 2'b11; req_plot = 2'b01;
    req_x[0] = 8'd40; req_y[0] = 7'd40;
    rst = 1'b1;
    tick();
    n_cmp++; if (gnt !== 2'b00 || vga_plot !== 1'b0 || clip_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midrst: got gnt=%b plot=%b clip=%0d want 00,0,0", gnt, vga_plot, clip_cnt);
    end
    n_cmp++; if (state_dbg !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got state=%0d busy=%b want IDLE,0", state_dbg, busy); end
    rst = 1'b0; req = 2'b00; req_plot = 2'b00;
    tick();
    n_cmp++; if (vga_plot !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL midrst_after: got plot=%b state=%0d want 0,IDLE", vga_plot, state_dbg); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_clip();
    test_ungranted_plot();
    test_reset_mid_burst();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL exp_q_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
